// File: rtl/store_drain_ctrl_pkg.sv
// Shared cpu types for the store-drain / load arbitration path to the data port.
package store_drain_ctrl_pkg;

  typedef logic [31:0] virt_t;
  typedef logic [31:0] uint32_t;

  typedef struct packed {
    logic [3:0] wstrb;
    logic [2:0] size;
    virt_t      addr;
    uint32_t    data;
  } st_buffer_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    LD_ADDR = 3'd3,
    LD_DATA = 3'd4
  } sd_state_e;

  typedef struct packed {
    logic       wr;
    logic [2:0] size;
    logic [3:0] wstrb;
    virt_t      addr;
    uint32_t    wdata;
  } mem_req_t;

endpackage

// File: rtl/store_drain_ctrl.sv
// Arbitrates committed-store drain vs. loads onto a split addr/data handshake port.
// Optional perf counters are built only with STORE_DRAIN_PERF_EN defined.
module store_drain_ctrl
  import store_drain_ctrl_pkg::*;
#(
  parameter int STORE_GROUP  = 16,
  parameter int DRAIN_THRESH = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        rob_commit_store,
  output logic        store_drained,
  output logic        sb_pop,
  input  logic [3:0]  sb_wstrb,
  input  logic [2:0]  sb_size,
  input  virt_t       sb_addr,
  input  uint32_t     sb_data,
  input  logic        ld_req,
  input  logic [2:0]  ld_size,
  input  virt_t       ld_addr,
  output logic        ld_grant,
  output logic        ld_data_ok,
  output uint32_t     ld_rdata,
  output logic        data_req,
  output logic        data_wr,
  output logic [2:0]  data_size,
  output logic [3:0]  data_wstrb,
  output virt_t       data_addr,
  output uint32_t     data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  uint32_t     data_rdata,
  output logic [31:0] perf_st_cnt,
  output logic [31:0] perf_ld_stall
);

  localparam int CW = $clog2(STORE_GROUP) + 1;
  localparam logic [CW-1:0] THRESH_C = CW'(DRAIN_THRESH);
  localparam logic [CW-1:0] FULL_C   = CW'(STORE_GROUP);

  logic [CW-1:0] r_pending_cnt;
  sd_state_e     r_state, w_state_nxt;
  mem_req_t      r_req, w_req_nxt;
  logic          r_ld_kill, w_ld_kill_nxt;
  logic          w_sel_store, w_sel_load, w_ld_done, w_st_done;
  st_buffer_t    w_sb_head;

  assign w_sb_head = '{wstrb: sb_wstrb, size: sb_size, addr: sb_addr, data: sb_data};

  always_comb begin
    w_state_nxt   = r_state;
    w_req_nxt     = r_req;
    w_ld_kill_nxt = r_ld_kill;
    w_sel_store   = 1'b0;
    w_sel_load    = 1'b0;
    w_ld_done     = 1'b0;
    w_st_done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_pending_cnt != '0 && (r_pending_cnt >= THRESH_C || !ld_req)) begin
          w_sel_store     = 1'b1;
          w_req_nxt.wr    = 1'b1;
          w_req_nxt.size  = w_sb_head.size;
          w_req_nxt.wstrb = w_sb_head.wstrb;
          w_req_nxt.addr  = w_sb_head.addr;
          w_req_nxt.wdata = w_sb_head.data;
          w_state_nxt     = ST_ADDR;
        end else if (ld_req && !flush) begin
          w_sel_load      = 1'b1;
          w_req_nxt.wr    = 1'b0;
          w_req_nxt.size  = ld_size;
          w_req_nxt.wstrb = 4'h0;
          w_req_nxt.addr  = ld_addr;
          w_req_nxt.wdata = '0;
          w_ld_kill_nxt   = 1'b0;
          w_state_nxt     = LD_ADDR;
        end
      end
      ST_ADDR: if (data_addr_ok) w_state_nxt = ST_DATA;
      ST_DATA: begin
        if (data_data_ok) begin
          w_st_done   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      LD_ADDR: begin
        // An accepted address must still see its data beat; only an unaccepted one can be dropped.
        if (data_addr_ok) begin
          w_state_nxt = LD_DATA;
          if (flush) w_ld_kill_nxt = 1'b1;
        end else if (flush) begin
          w_state_nxt = IDLE;
        end
      end
      LD_DATA: begin
        if (flush) w_ld_kill_nxt = 1'b1;
        if (data_data_ok) begin
          w_ld_done   = !flush && !r_ld_kill;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_req     <= '0;
      r_ld_kill <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_req     <= w_req_nxt;
      r_ld_kill <= w_ld_kill_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending_cnt <= '0;
    end else if (rob_commit_store && !sb_pop) begin
      r_pending_cnt <= r_pending_cnt + 1'b1;
    end else if (!rob_commit_store && sb_pop) begin
      r_pending_cnt <= r_pending_cnt - 1'b1;
    end
  end

  assign sb_pop        = w_sel_store && !reset;
  assign ld_grant      = w_sel_load && !reset;
  assign ld_data_ok    = w_ld_done && !reset;
  assign ld_rdata      = data_rdata;
  assign data_req      = !reset && (r_state == ST_ADDR || r_state == LD_ADDR);
  assign data_wr       = r_req.wr;
  assign data_size     = r_req.size;
  assign data_wstrb    = r_req.wstrb;
  assign data_addr     = r_req.addr;
  assign data_wdata    = r_req.wdata;
  assign store_drained = reset ||
                         (r_pending_cnt == '0 && r_state != ST_ADDR && r_state != ST_DATA);

`ifdef STORE_DRAIN_PERF_EN
  logic [31:0] r_perf_st_cnt;
  logic [31:0] r_perf_ld_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_st_cnt   <= '0;
      r_perf_ld_stall <= '0;
    end else begin
      if (w_st_done) r_perf_st_cnt <= r_perf_st_cnt + 32'd1;
      if (ld_req && !ld_grant) r_perf_ld_stall <= r_perf_ld_stall + 32'd1;
    end
  end

  assign perf_st_cnt   = r_perf_st_cnt;
  assign perf_ld_stall = r_perf_ld_stall;
`else
  assign perf_st_cnt   = 32'd0;
  assign perf_ld_stall = 32'd0;
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(rob_commit_store && !sb_pop && r_pending_cnt == FULL_C));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(sb_pop && !rob_commit_store && r_pending_cnt == '0));

endmodule

// File: tb/tb_store_drain_ctrl.sv
// Directed bench for store_drain_ctrl: drain, priority, backpressure, flush, reset, perf.
module tb_store_drain_ctrl;
  import store_drain_ctrl_pkg::*;

  logic        clk, reset, flush, rob_commit_store, store_drained, sb_pop;
  logic [3:0]  sb_wstrb;
  logic [2:0]  sb_size;
  virt_t       sb_addr;
  uint32_t     sb_data;
  logic        ld_req;
  logic [2:0]  ld_size;
  virt_t       ld_addr;
  logic        ld_grant, ld_data_ok;
  uint32_t     ld_rdata;
  logic        data_req, data_wr;
  logic [2:0]  data_size;
  logic [3:0]  data_wstrb;
  virt_t       data_addr;
  uint32_t     data_wdata;
  logic        data_addr_ok, data_data_ok;
  uint32_t     data_rdata;
  logic [31:0] perf_st_cnt, perf_ld_stall;

  int checks = 0;
  int errors = 0;

  store_drain_ctrl #(.STORE_GROUP(16), .DRAIN_THRESH(12)) dut (
    .clk(clk), .reset(reset), .flush(flush), .rob_commit_store(rob_commit_store),
    .store_drained(store_drained), .sb_pop(sb_pop), .sb_wstrb(sb_wstrb), .sb_size(sb_size),
    .sb_addr(sb_addr), .sb_data(sb_data), .ld_req(ld_req), .ld_size(ld_size),
    .ld_addr(ld_addr), .ld_grant(ld_grant), .ld_data_ok(ld_data_ok), .ld_rdata(ld_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .perf_st_cnt(perf_st_cnt), .perf_ld_stall(perf_ld_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    flush = 0; rob_commit_store = 0; ld_req = 0; ld_size = 0; ld_addr = 0;
    sb_wstrb = 0; sb_size = 0; sb_addr = 0; sb_data = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
  endtask

  task automatic do_reset();
    cyc(); clear_inputs(); reset = 1;
    cyc(); cyc(); reset = 0;
  endtask

  task automatic test_reset();
    cyc(); reset = 1; ld_req = 1; #1;
    checks++; if (sb_pop !== 1'b0) begin errors++; $display("FAIL rst_sb_pop got %b want 0", sb_pop); end
    checks++; if (ld_grant !== 1'b0) begin errors++; $display("FAIL rst_ld_grant got %b want 0", ld_grant); end
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL rst_data_req got %b want 0", data_req); end
    checks++; if (store_drained !== 1'b1) begin errors++; $display("FAIL rst_drained got %b want 1", store_drained); end
    cyc(); clear_inputs(); reset = 0; #1;
    checks++; if (store_drained !== 1'b1) begin errors++; $display("FAIL post_rst_drained got %b want 1", store_drained); end
    checks++; if (data_req !== 1'b0 || ld_data_ok !== 1'b0) begin errors++; $display("FAIL post_rst_req got %b/%b want 0/0", data_req, ld_data_ok); end
    checks++; if (perf_st_cnt !== 32'd0 || perf_ld_stall !== 32'd0) begin errors++; $display("FAIL rst_perf got %0d/%0d want 0/0", perf_st_cnt, perf_ld_stall); end
  endtask

  // Also covers commit+pop in the same cycle at pending=1 (cycle 1): a miscount would add a 4th pop.
  task automatic test_drain();
    int pops[$];
    for (int c = 0; c < 16; c++) begin
      cyc();
      rob_commit_store = (c < 3); sb_addr = 32'h1000 + c; sb_data = 32'hA000 + c;
      sb_wstrb = 4'hF; sb_size = 3'd2; data_addr_ok = 1; data_data_ok = 1; #1;
      if (sb_pop === 1'b1) pops.push_back(c);
      if (c == 2) begin
        checks++; if (data_req !== 1'b1 || data_wr !== 1'b1) begin errors++; $display("FAIL drain_req got %b/%b want 1/1", data_req, data_wr); end
        checks++; if (data_addr !== 32'h1001 || data_wdata !== 32'hA001) begin errors++; $display("FAIL drain_fields got %h/%h want 1001/a001", data_addr, data_wdata); end
      end
      if (c == 9) begin
        checks++; if (store_drained !== 1'b0) begin errors++; $display("FAIL drain_busy got %b want 0", store_drained); end
      end
    end
    checks++; if (pops.size() != 3) begin errors++; $display("FAIL drain_pop_count got %0d want 3", pops.size()); end
    for (int i = 0; i < 3 && i < pops.size(); i++) begin
      checks++; if (pops[i] != 1 + 3 * i) begin errors++; $display("FAIL drain_pop_cycle%0d got %0d want %0d", i, pops[i], 1 + 3 * i); end
    end
    checks++; if (store_drained !== 1'b1) begin errors++; $display("FAIL drain_done got %b want 1", store_drained); end
    clear_inputs();
  endtask

  task automatic test_priority();
    int pops;
    for (int c = 0; c < 2; c++) begin
      cyc(); rob_commit_store = 1; ld_req = 1; flush = 1; #1;
    end
    cyc(); rob_commit_store = 0; flush = 0; ld_req = 1; ld_addr = 32'h2000; ld_size = 3'd2; #1;
    checks++; if (ld_grant !== 1'b1 || sb_pop !== 1'b0) begin errors++; $display("FAIL prio_low got grant=%b pop=%b want 1/0", ld_grant, sb_pop); end
    cyc(); ld_req = 0; data_addr_ok = 1; #1;
    checks++; if (data_req !== 1'b1 || data_wr !== 1'b0 || data_wstrb !== 4'h0 || data_addr !== 32'h2000)
      begin errors++; $display("FAIL ld_addr_phase got req=%b wr=%b strb=%h addr=%h want 1/0/0/2000", data_req, data_wr, data_wstrb, data_addr); end
    cyc(); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hCAFE0001; #1;
    checks++; if (ld_data_ok !== 1'b1 || ld_rdata !== 32'hCAFE0001) begin errors++; $display("FAIL ld_data got ok=%b data=%h want 1/cafe0001", ld_data_ok, ld_rdata); end
    pops = 0;
    for (int c = 0; c < 9; c++) begin
      cyc(); data_addr_ok = 1; data_data_ok = 1; #1;
      if (sb_pop === 1'b1) pops++;
    end
    checks++; if (pops != 2 || store_drained !== 1'b1) begin errors++; $display("FAIL prio_low_drain got pops=%0d drained=%b want 2/1", pops, store_drained); end
    clear_inputs();
    for (int c = 0; c < 12; c++) begin
      cyc(); rob_commit_store = 1; ld_req = 1; flush = 1; #1;
    end
    cyc(); rob_commit_store = 0; flush = 0; ld_req = 1; data_addr_ok = 1; data_data_ok = 1; #1;
    checks++; if (sb_pop !== 1'b1 || ld_grant !== 1'b0) begin errors++; $display("FAIL prio_thresh got pop=%b grant=%b want 1/0", sb_pop, ld_grant); end
    cyc(); #1; cyc(); #1;
    cyc(); #1;
    checks++; if (ld_grant !== 1'b1 || sb_pop !== 1'b0) begin errors++; $display("FAIL prio_below got grant=%b pop=%b want 1/0", ld_grant, sb_pop); end
    cyc(); ld_req = 0; #1;
    pops = 0;
    for (int c = 0; c < 40; c++) begin
      cyc(); #1;
      if (sb_pop === 1'b1) pops++;
    end
    checks++; if (pops != 11 || store_drained !== 1'b1) begin errors++; $display("FAIL prio_high_drain got pops=%0d drained=%b want 11/1", pops, store_drained); end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    cyc(); rob_commit_store = 1; #1;
    cyc(); rob_commit_store = 0; sb_addr = 32'h3000; sb_data = 32'h5555AAAA; sb_wstrb = 4'h3; sb_size = 3'd1; #1;
    checks++; if (sb_pop !== 1'b1) begin errors++; $display("FAIL bp_pop got %b want 1", sb_pop); end
    for (int i = 0; i < 5; i++) begin
      cyc(); sb_addr = 32'hDEAD0000 + i; sb_data = 32'h0BAD0000 + i; sb_wstrb = 4'hC; #1;
      checks++; if (data_req !== 1'b1 || sb_pop !== 1'b0) begin errors++; $display("FAIL bp_hold%0d got req=%b pop=%b want 1/0", i, data_req, sb_pop); end
      checks++; if (data_addr !== 32'h3000 || data_wdata !== 32'h5555AAAA || data_wstrb !== 4'h3 || data_size !== 3'd1)
        begin errors++; $display("FAIL bp_fields%0d got %h/%h/%h/%0d want 3000/5555aaaa/3/1", i, data_addr, data_wdata, data_wstrb, data_size); end
    end
    cyc(); data_addr_ok = 1; #1;
    checks++; if (data_req !== 1'b1) begin errors++; $display("FAIL bp_accept got %b want 1", data_req); end
    for (int i = 0; i < 2; i++) begin
      cyc(); data_addr_ok = 0; #1;
      checks++; if (data_req !== 1'b0 || store_drained !== 1'b0) begin errors++; $display("FAIL bp_data_wait%0d got req=%b drained=%b want 0/0", i, data_req, store_drained); end
    end
    cyc(); data_data_ok = 1; #1;
    cyc(); data_data_ok = 0; #1;
    checks++; if (store_drained !== 1'b1 || sb_pop !== 1'b0) begin errors++; $display("FAIL bp_done got drained=%b pop=%b want 1/0", store_drained, sb_pop); end
    clear_inputs();
  endtask

  task automatic test_flush();
    cyc(); ld_req = 1; ld_addr = 32'h4000; #1;
    checks++; if (ld_grant !== 1'b1) begin errors++; $display("FAIL fl_grant0 got %b want 1", ld_grant); end
    cyc(); ld_req = 0; flush = 1; #1;
    checks++; if (data_req !== 1'b1) begin errors++; $display("FAIL fl_addr_req got %b want 1", data_req); end
    cyc(); flush = 0; ld_req = 1; ld_addr = 32'h4100; #1;
    checks++; if (data_req !== 1'b0 || ld_grant !== 1'b1 || ld_data_ok !== 1'b0)
      begin errors++; $display("FAIL fl_addr_drop got req=%b grant=%b dok=%b want 0/1/0", data_req, ld_grant, ld_data_ok); end
    cyc(); ld_req = 0; data_addr_ok = 1; #1;
    cyc(); data_addr_ok = 0; flush = 1; data_data_ok = 1; data_rdata = 32'h1111; #1;
    checks++; if (ld_data_ok !== 1'b0) begin errors++; $display("FAIL fl_data_suppress got %b want 0", ld_data_ok); end
    cyc(); flush = 0; data_data_ok = 0; ld_req = 1; ld_addr = 32'h4200; #1;
    checks++; if (ld_grant !== 1'b1) begin errors++; $display("FAIL fl_grant2 got %b want 1", ld_grant); end
    cyc(); ld_req = 0; data_addr_ok = 1; flush = 1; #1;
    cyc(); data_addr_ok = 0; flush = 0; data_data_ok = 1; #1;
    checks++; if (ld_data_ok !== 1'b0 || data_req !== 1'b0) begin errors++; $display("FAIL fl_accept_suppress got dok=%b req=%b want 0/0", ld_data_ok, data_req); end
    cyc(); data_data_ok = 0; ld_req = 1; ld_addr = 32'h4300; #1;
    checks++; if (ld_grant !== 1'b1) begin errors++; $display("FAIL fl_grant3 got %b want 1", ld_grant); end
    cyc(); ld_req = 0; data_addr_ok = 1; #1;
    cyc(); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h77; #1;
    checks++; if (ld_data_ok !== 1'b1 || ld_rdata !== 32'h77) begin errors++; $display("FAIL fl_clean_load got dok=%b data=%h want 1/77", ld_data_ok, ld_rdata); end
    cyc(); clear_inputs();
  endtask

  task automatic test_reset_mid();
    cyc(); rob_commit_store = 1; #1;
    cyc(); rob_commit_store = 0; #1;
    checks++; if (sb_pop !== 1'b1) begin errors++; $display("FAIL rm_pop got %b want 1", sb_pop); end
    cyc(); #1;
    checks++; if (data_req !== 1'b1) begin errors++; $display("FAIL rm_req got %b want 1", data_req); end
    cyc(); reset = 1; #1;
    checks++; if (data_req !== 1'b0 || store_drained !== 1'b1) begin errors++; $display("FAIL rm_in_reset got req=%b drained=%b want 0/1", data_req, store_drained); end
    cyc(); reset = 0; data_addr_ok = 1; data_data_ok = 1; #1;
    checks++; if (data_req !== 1'b0 || sb_pop !== 1'b0 || store_drained !== 1'b1)
      begin errors++; $display("FAIL rm_abandon got req=%b pop=%b drained=%b want 0/0/1", data_req, sb_pop, store_drained); end
    cyc(); #1;
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL rm_idle got %b want 0", data_req); end
    clear_inputs();
  endtask

  task automatic test_perf();
    logic [31:0] exp_st, exp_stall;
`ifdef STORE_DRAIN_PERF_EN
    exp_st = 32'd4; exp_stall = 32'd7;
`else
    exp_st = 32'd0; exp_stall = 32'd0;
`endif
    do_reset();
    for (int c = 0; c < 7; c++) begin
      cyc(); flush = 1; ld_req = 1; #1;
    end
    cyc(); flush = 0; ld_req = 0;
    for (int c = 0; c < 24; c++) begin
      cyc(); rob_commit_store = (c < 4); data_addr_ok = 1; data_data_ok = 1; #1;
    end
    checks++; if (perf_st_cnt !== exp_st) begin errors++; $display("FAIL perf_st got %0d want %0d", perf_st_cnt, exp_st); end
    checks++; if (perf_ld_stall !== exp_stall) begin errors++; $display("FAIL perf_stall got %0d want %0d", perf_ld_stall, exp_stall); end
    checks++; if (store_drained !== 1'b1) begin errors++; $display("FAIL perf_drained got %b want 1", store_drained); end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_drain();
    test_priority();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_perf();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
